pair_sched: RTL and testbench

- Scheduler that sequences the all-pairs (i,j) sweep feeding the fixed-latency acceleration pipeline.
- Generates position/mass read addresses each cycle and tags every issued pair.
- Replays each tag exactly PIPE_LATENCY cycles later as a writeback/accumulate strobe for the velocity-update stage.
- Sits between the top-level run controller (start/abort) and the body RAMs plus the accel datapath.

---
 rtl/pair_sched_if.sv | 30 +++
 rtl/pair_sched.sv | 151 +++++++++++++++
 tb/tb_pair_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pair_sched_if.sv
// Control and pair/tag bus between the run controller, the body RAMs and the accel pipeline.
// The master drives start/abort/configuration; the slave is the pair scheduler.
interface pair_sched_if #(
    parameter int BODY_ADDR_WIDTH = 9
);
    logic                       start;
    logic                       abort;
    logic [BODY_ADDR_WIDTH:0]   num_bodies;
    logic                       skip_self;
    logic                       busy;
    logic                       done;
    logic                       rd_valid;
    logic [BODY_ADDR_WIDTH-1:0] rd_i;
    logic [BODY_ADDR_WIDTH-1:0] rd_j;
    logic                       wb_valid;
    logic [BODY_ADDR_WIDTH-1:0] wb_i;
    logic [BODY_ADDR_WIDTH-1:0] wb_j;
    logic                       wb_first;
    logic                       wb_last;

    modport master (
        output start, abort, num_bodies, skip_self,
        input  busy, done, rd_valid, rd_i, rd_j, wb_valid, wb_i, wb_j, wb_first, wb_last
    );

    modport slave (
        input  start, abort, num_bodies, skip_self,
        output busy, done, rd_valid, rd_i, rd_j, wb_valid, wb_i, wb_j, wb_first, wb_last
    );
endinterface

// File: rtl/pair_sched.sv
// All-pairs (i,j) sweep scheduler with a fixed-latency tag delay line for writeback strobes.
// state | meaning:  IDLE | waiting for start,  ISSUE | one pair per cycle,  DRAIN | waiting for last tag to emerge
module pair_sched #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int PIPE_LATENCY    = 123
) (
    input logic         clk_i,
    input logic         rst_i,
    pair_sched_if.slave bus
);
    localparam int AW   = BODY_ADDR_WIDTH;
    localparam int NW   = AW + 1;
    localparam int TW   = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam int TAGW = 2 * AW + 3;
    localparam logic [NW-1:0] N_MAX    = NW'(BODIES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(PIPE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic            skip_q, skip_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_valid_q, valid_d;
    logic [AW-1:0]   rd_i_q, i_d;
    logic [AW-1:0]   rd_j_q, j_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [TAGW-1:0] line_q [PIPE_LATENCY];

    logic [NW-1:0] n_sat;
    logic [NW-1:0] nm1, nm2;
    logic          accept, i_end, j_end, sweep_end;

    assign n_sat     = (bus.num_bodies > N_MAX) ? N_MAX : bus.num_bodies;
    assign accept    = (state_q == IDLE) && bus.start && !bus.abort;
    assign i_end     = ({1'b0, rd_i_q} == n_q - NW'(1));
    assign j_end     = ({1'b0, rd_j_q} == n_q - NW'(1));
    assign sweep_end = i_end && j_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (n_sat == '0) ? DRAIN : ISSUE;
            ISSUE:   if (sweep_end) state_d = DRAIN;
            DRAIN:   if (tmr_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) state_d = IDLE;
    end

    always_comb begin
        n_d     = n_q;
        skip_d  = skip_q;
        i_d     = rd_i_q;
        j_d     = rd_j_q;
        tmr_d   = tmr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                n_d     = n_sat;
                skip_d  = bus.skip_self;
                i_d     = '0;
                j_d     = '0;
                busy_d  = 1'b1;
                tmr_d   = TMR_LOAD;
                valid_d = (n_sat != '0) && !bus.skip_self;
            end
            ISSUE: if (sweep_end) begin
                tmr_d = TMR_LOAD;
            end else begin
                if (j_end) begin
                    j_d = '0;
                    i_d = rd_i_q + AW'(1);
                end else begin
                    j_d = rd_j_q + AW'(1);
                end
                valid_d = !(skip_q && (i_d == j_d));
            end
            DRAIN: if (tmr_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
            default: ;
        endcase
        if (bus.abort) begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            valid_d = 1'b0;
        end
        // With skip_self the row boundaries move inward at the diagonal corners.
        nm1     = n_d - NW'(1);
        nm2     = n_d - NW'(2);
        first_d = (j_d == '0) || ((j_d == AW'(1)) && (i_d == '0) && skip_d);
        last_d  = ({1'b0, j_d} == nm1) ||
                  (({1'b0, j_d} == nm2) && ({1'b0, i_d} == nm1) && skip_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q        <= '0;
            skip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_i_q     <= '0;
            rd_j_q     <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            tmr_q      <= '0;
            for (int k = 0; k < PIPE_LATENCY; k++) line_q[k] <= '0;
        end else begin
            n_q        <= n_d;
            skip_q     <= skip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= valid_d;
            rd_i_q     <= i_d;
            rd_j_q     <= j_d;
            first_q    <= first_d;
            last_q     <= last_d;
            tmr_q      <= tmr_d;
            line_q[0]  <= {rd_valid_q & ~bus.abort, rd_i_q, rd_j_q, first_q, last_q};
            for (int k = 1; k < PIPE_LATENCY; k++)
                line_q[k] <= {line_q[k-1][TAGW-1] & ~bus.abort, line_q[k-1][TAGW-2:0]};
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_i     = rd_i_q;
    assign bus.rd_j     = rd_j_q;
    assign bus.wb_valid = line_q[PIPE_LATENCY-1][TAGW-1];
    assign bus.wb_i     = line_q[PIPE_LATENCY-1][TAGW-2 -: AW];
    assign bus.wb_j     = line_q[PIPE_LATENCY-1][TAGW-2-AW -: AW];
    assign bus.wb_first = line_q[PIPE_LATENCY-1][1];
    assign bus.wb_last  = line_q[PIPE_LATENCY-1][0];
endmodule

// File: tb/tb_pair_sched.sv
// Directed bench for pair_sched with BODIES=4, PIPE_LATENCY=4; cycle c is the period after the c-th edge following start.
module tb_pair_sched;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pair_sched_if #(.BODY_ADDR_WIDTH(AW)) bus ();

    pair_sched #(.BODIES(4), .BODY_ADDR_WIDTH(AW), .PIPE_LATENCY(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag, input int c);
        chk({tag, " busy"},     c, 32'(bus.busy),     32'd0);
        chk({tag, " done"},     c, 32'(bus.done),     32'd0);
        chk({tag, " rd_valid"}, c, 32'(bus.rd_valid), 32'd0);
        chk({tag, " wb_valid"}, c, 32'(bus.wb_valid), 32'd0);
        chk({tag, " rd_i"},     c, 32'(bus.rd_i),     32'd0);
        chk({tag, " rd_j"},     c, 32'(bus.rd_j),     32'd0);
        chk({tag, " wb_i"},     c, 32'(bus.wb_i),     32'd0);
        chk({tag, " wb_j"},     c, 32'(bus.wb_j),     32'd0);
    endtask

    // Masks hold the expected value of each strobe at cycle c in bit c; pair indices follow i-major order.
    task automatic sweep(input string nm, input int nb, input bit sk, input int eff, input int ncyc,
                         input logic [31:0] m_busy, input logic [31:0] m_done,
                         input logic [31:0] m_rv, input logic [31:0] m_wv,
                         input logic [31:0] m_wf, input logic [31:0] m_wl, input bit poke);
        bus.start      = 1'b1;
        bus.num_bodies = 3'(nb);
        bus.skip_self  = sk;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            bus.start = 1'b0;
            chk({nm, " busy"},     c, 32'(bus.busy),                  32'(m_busy[c]));
            chk({nm, " done"},     c, 32'(bus.done),                  32'(m_done[c]));
            chk({nm, " rd_valid"}, c, 32'(bus.rd_valid),              32'(m_rv[c]));
            chk({nm, " wb_valid"}, c, 32'(bus.wb_valid),              32'(m_wv[c]));
            chk({nm, " wb_first"}, c, 32'(bus.wb_first & bus.wb_valid), 32'(m_wf[c]));
            chk({nm, " wb_last"},  c, 32'(bus.wb_last & bus.wb_valid),  32'(m_wl[c]));
            if (c <= eff * eff) begin
                chk({nm, " rd_i"}, c, 32'(bus.rd_i), 32'((c - 1) / eff));
                chk({nm, " rd_j"}, c, 32'(bus.rd_j), 32'((c - 1) % eff));
            end
            if (c >= 5 && c <= eff * eff + 4) begin
                chk({nm, " wb_i"}, c, 32'(bus.wb_i), 32'((c - 5) / eff));
                chk({nm, " wb_j"}, c, 32'(bus.wb_j), 32'((c - 5) % eff));
            end
            if (poke && c == 4) begin
                bus.start      = 1'b1;
                bus.num_bodies = 3'(1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.num_bodies = '0;
        bus.skip_self  = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset", 0);
        rst = 1'b0;
        tick();

        // Basic N=3 sweep, then a second one started on the done cycle.
        sweep("basic", 3, 1'b0, 3, 14, 32'h3FFE, 32'h4000, 32'h03FE, 32'h3FE0, 32'h0920, 32'h2480, 1'b0);
        sweep("b2b",   3, 1'b0, 3, 15, 32'h3FFE, 32'h4000, 32'h03FE, 32'h3FE0, 32'h0920, 32'h2480, 1'b0);
        repeat (2) tick();

        // skip_self with a stray start and num_bodies change mid-sweep.
        sweep("skip", 3, 1'b1, 3, 15, 32'h3FFE, 32'h4000, 32'h01DC, 32'h1DC0, 32'h0940, 32'h1480, 1'b1);
        tick();

        sweep("n1skip", 1, 1'b1, 1, 7, 32'h003E, 32'h0040, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        sweep("n0", 0, 1'b0, 0, 7, 32'h001E, 32'h0020, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        // num_bodies=6 saturates to 4.
        sweep("sat", 6, 1'b0, 4, 22, 32'h001FFFFE, 32'h00200000, 32'h0001FFFE, 32'h001FFFE0,
              32'h00022220, 32'h00111100, 1'b0);
        tick();

        // Abort at cycle 6, restart at cycle 10.
        sweep("pre_abort", 3, 1'b0, 3, 6, 32'h3FFE, 32'h4000, 32'h03FE, 32'h3FE0, 32'h0920, 32'h2480, 1'b0);
        bus.abort = 1'b1;
        for (int c = 7; c <= 9; c++) begin
            tick();
            bus.abort = 1'b0;
            chk("abort busy",     c, 32'(bus.busy),     32'd0);
            chk("abort done",     c, 32'(bus.done),     32'd0);
            chk("abort rd_valid", c, 32'(bus.rd_valid), 32'd0);
            chk("abort wb_valid", c, 32'(bus.wb_valid), 32'd0);
        end
        tick();
        sweep("restart", 3, 1'b0, 3, 15, 32'h3FFE, 32'h4000, 32'h03FE, 32'h3FE0, 32'h0920, 32'h2480, 1'b0);
        tick();

        // abort and start together: nothing starts.
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.num_bodies = 3'(3);
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            chk("abort_start busy",     c, 32'(bus.busy),     32'd0);
            chk("abort_start rd_valid", c, 32'(bus.rd_valid), 32'd0);
        end

        // rst at cycle 3 of a sweep.
        sweep("pre_rst", 3, 1'b0, 3, 3, 32'h3FFE, 32'h4000, 32'h03FE, 32'h3FE0, 32'h0920, 32'h2480, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid_rst", 4);
        for (int c = 5; c <= 12; c++) begin
            tick();
            chk("post_rst wb_valid", c, 32'(bus.wb_valid), 32'd0);
            chk("post_rst busy",     c, 32'(bus.busy),     32'd0);
            chk("post_rst done",     c, 32'(bus.done),     32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
